// File: rtl/wb_burst_reader_pkg.sv
// Shared constants and types for the Wishbone burst reader.
package wb_burst_pkg;

  // Wishbone cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Reader control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    BURST = 2'd2
  } state_e;

endpackage

// File: rtl/wb_burst_reader_if.sv
// Wishbone bus bundle carrying clock and reset alongside the bus wires.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_ms;
  logic        ack;
  logic [31:0] dat_sm;

  modport master (
    input  clk, rst, ack, dat_sm,
    output cyc, stb, we, sel, adr, cti, bte, dat_ms
  );

  modport slave (
    input  clk, rst, cyc, stb, we, sel, adr, cti, bte, dat_ms,
    output ack, dat_sm
  );
endinterface

// File: rtl/wb_burst_reader_fifo.sv
// Show-ahead synchronous FIFO plus its overflow checker.
module fifo_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_dat,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head_dat,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_pop;

  // Pointer advance with explicit wrap so non-power-of-two corner cases stay in range.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + {{(AW-1){1'b0}}, 1'b1};
    end
  endfunction

  assign do_pop   = pop && (count_q != {CW{1'b0}});
  assign head_dat = mem_q[rd_ptr_q];
  assign empty    = (count_q == {CW{1'b0}});
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// Flags a push into a full FIFO that is not relieved by a pop in the same cycle.
module fifo_sync_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone burst master streaming a word block into a show-ahead FIFO.
module wb_burst_reader
  import wb_burst_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  wshb_if.master      wb_m,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [15:0] nb_words,
  output logic        busy,
  output logic        done,
  output logic [31:0] out_dat,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [31:0]       adr_q, adr_d;
  logic [15:0]       rem_q, rem_d;
  logic [BEAT_W-1:0] beats_q, beats_d, beats_calc;
  logic              cyc_q, cyc_d;
  logic [2:0]        cti_q, cti_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_dat_q, out_dat_d;

  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [31:0]       fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              credit_ok;

  assign wb_m.cyc    = cyc_q;
  assign wb_m.stb    = cyc_q;
  assign wb_m.we     = 1'b0;
  assign wb_m.sel    = 4'hF;
  assign wb_m.bte    = 2'b00;
  assign wb_m.dat_ms = 32'd0;
  assign wb_m.adr    = adr_q;
  assign wb_m.cti    = cti_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_dat   = out_dat_q;
  assign out_valid = out_valid_q;

  assign fifo_push = (state_q == BURST) && wb_m.ack;
  // Refill the output register whenever it is empty or being consumed.
  assign fifo_pop  = !fifo_empty && (!out_valid_q || out_ready);
  // Only launch a burst when every beat is guaranteed a FIFO slot.
  assign credit_ok = (32'(fifo_count) + 32'(beats_calc)) <= 32'(FIFO_DEPTH);

  // Beats for the next burst: the lesser of the burst limit and the words left.
  always_comb begin
    if (rem_q >= 16'(BURST_LEN)) begin
      beats_calc = BEAT_W'(BURST_LEN);
    end else begin
      beats_calc = BEAT_W'(rem_q);
    end
  end

  // Burst sequencing: latch request, wait for FIFO credit, run one burst at a time.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    cyc_d   = cyc_q;
    cti_d   = cti_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          adr_d   = {base_adr[31:2], 2'b00};
          rem_d   = nb_words;
          busy_d  = 1'b1;
          state_d = CHECK;
        end else begin
          cyc_d = 1'b0;
        end
      end
      CHECK: begin
        if (rem_q == 16'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (credit_ok) begin
          beats_d = beats_calc;
          cyc_d   = 1'b1;
          cti_d   = (beats_calc == BEAT_W'(1)) ? CTI_EOB : CTI_INCR;
          state_d = BURST;
        end else begin
          cyc_d = 1'b0;
        end
      end
      BURST: begin
        if (wb_m.ack) begin
          adr_d   = adr_q + 32'd4;
          beats_d = beats_q - BEAT_W'(1);
          rem_d   = rem_q - 16'd1;
          if (beats_q == BEAT_W'(1)) begin
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
            state_d = CHECK;
          end else begin
            cti_d = (beats_q == BEAT_W'(2)) ? CTI_EOB : CTI_INCR;
          end
        end else begin
          cyc_d = 1'b1;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        cti_d   = CTI_CLASSIC;
        state_d = IDLE;
      end
    endcase
  end

  // Output register in front of the FIFO head.
  always_comb begin
    out_valid_d = out_valid_q;
    out_dat_d   = out_dat_q;
    if (fifo_pop) begin
      out_valid_d = 1'b1;
      out_dat_d   = fifo_head;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control and output state; reset aborts any burst without a completion pulse.
  always_ff @(posedge wb_m.clk or posedge wb_m.rst) begin
    if (wb_m.rst) begin
      state_q     <= IDLE;
      adr_q       <= 32'd0;
      rem_q       <= 16'd0;
      beats_q     <= {BEAT_W{1'b0}};
      cyc_q       <= 1'b0;
      cti_q       <= CTI_CLASSIC;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_dat_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      rem_q       <= rem_d;
      beats_q     <= beats_d;
      cyc_q       <= cyc_d;
      cti_q       <= cti_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_dat_q   <= out_dat_d;
    end
  end

  fifo_sync #(
    .DATA_W (32),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (wb_m.clk),
    .rst      (wb_m.rst),
    .push     (fifo_push),
    .push_dat (wb_m.dat_sm),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  fifo_sync_chk u_fifo_chk (
    .clk  (wb_m.clk),
    .rst  (wb_m.rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .full (fifo_full)
  );
endmodule

// File: tb/tb_wb_burst_reader.sv
// Randomized bench for wb_burst_reader against a transfer-level reference model.
module tb_wb_burst_reader;
  localparam int BL = 16;
  localparam int FD = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_adr = 32'd0;
  logic [15:0] nb_words = 16'd0;
  logic        busy, done, out_valid;
  logic [31:0] out_dat;
  logic        out_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [4096];
  logic [31:0] exp_q [$];
  logic [31:0] xfer_base = 32'd0;
  int          xfer_n = 0, acked = 0, burst_beats = 0, beat_in_burst = 0;
  int          bursts = 0, done_cnt = 0, wait_left = 0, wait_max = 0, rdy_mode = 1;
  bit          prev_cyc = 1'b0, need_gap = 1'b0;

  always #5 clk = ~clk;

  wshb_if wb (.clk(clk), .rst(rst));

  wb_burst_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
    .wb_m      (wb),
    .start     (start),
    .base_adr  (base_adr),
    .nb_words  (nb_words),
    .busy      (busy),
    .done      (done),
    .out_dat   (out_dat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Slave model and bus-level checks against the transfer model.
  always @(negedge clk) begin : bus_side
    if (rst) begin
      wb.ack    = 1'b0;
      wb.dat_sm = 32'd0;
      prev_cyc  = 1'b0;
      need_gap  = 1'b0;
      wait_left = 0;
    end else begin
      if (need_gap) begin
        check_eq("gap_cyc", 32'(wb.cyc), 32'd0);
        need_gap = 1'b0;
      end
      if (wb.cyc) begin
        if (!prev_cyc) begin
          check_eq("cyc_with_work", 32'(xfer_n > acked), 32'd1);
          burst_beats   = ((xfer_n - acked) < BL) ? (xfer_n - acked) : BL;
          beat_in_burst = 0;
          bursts++;
        end
        check_eq("stb", 32'(wb.stb), 32'd1);
        check_eq("adr", wb.adr, xfer_base + 32'(acked * 4));
        check_eq("cti", 32'(wb.cti), (beat_in_burst == burst_beats - 1) ? 32'd7 : 32'd2);
        if (wait_left == 0) begin
          wb.ack    = 1'b1;
          wb.dat_sm = mem[wb.adr[13:2]];
          acked++;
          beat_in_burst++;
          if (beat_in_burst >= burst_beats) need_gap = 1'b1;
          wait_left = int'($urandom_range(0, wait_max));
        end else begin
          wb.ack    = 1'b0;
          wb.dat_sm = 32'hDEAD_BEEF;
          wait_left--;
        end
      end else begin
        wb.ack    = 1'b0;
        wb.dat_sm = 32'hDEAD_BEEF;
      end
      prev_cyc = wb.cyc;
    end
  end

  // Output stream scoreboard.
  always @(negedge clk) begin : out_side
    if (!rst) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        check_eq("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("out_dat", out_dat, exp_q.pop_front());
      end
    end
  end

  // Consumer readiness: held low, held high, or random.
  always @(posedge clk) begin : ready_drv
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic start_xfer(input logic [31:0] base, input int n, input int wmax);
    logic [11:0] idx;
    wait_max = wmax;
    for (int i = 0; i < n; i++) begin
      idx = 12'((base >> 2) + 32'(i));
      exp_q.push_back(mem[idx]);
    end
    @(posedge clk); #1;
    xfer_base = {base[31:2], 2'b00};
    xfer_n    = n;
    acked     = 0;
    bursts    = 0;
    start     = 1'b1;
    base_adr  = base;
    nb_words  = 16'(n);
    @(posedge clk); #1;
    start    = 1'b0;
    base_adr = $urandom;
    nb_words = 16'($urandom);
    @(negedge clk);
    check_eq("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic finish_xfer(input int n, output int done_at);
    done_at = 1;
    while (!done && done_at < 6000) begin
      @(negedge clk);
      done_at++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("busy_fall", 32'(busy), 32'd0);
    check_eq("acks", 32'(acked), 32'(n));
    @(negedge clk);
    check_eq("done_single", 32'(done), 32'd0);
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
    check_eq("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int d;
    int snap;
    logic [31:0] b;
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;

    // Reset state
    @(negedge clk);
    check_eq("rst_cyc", 32'(wb.cyc), 32'd0);
    check_eq("rst_stb", 32'(wb.stb), 32'd0);
    check_eq("rst_cti", 32'(wb.cti), 32'd0);
    check_eq("rst_adr", wb.adr, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_dat", out_dat, 32'd0);
    check_eq("bus_const", 32'({wb.we, wb.sel, wb.bte}), 32'h3C);
    check_eq("dat_ms", wb.dat_ms, 32'd0);
    #1 rst = 1'b0;
    rdy_mode = 1;

    // Zero-length request
    start_xfer(32'h0000_0040, 0, 0);
    finish_xfer(0, d);
    check_eq("zero_done_latency", 32'(d), 32'd2);
    check_eq("zero_bursts", 32'(bursts), 32'd0);

    // One full burst from an unaligned base, checking first-word latency
    start_xfer(32'h0000_0103, 16, 0);
    @(negedge clk);
    check_eq("first_cyc", 32'(wb.cyc), 32'd1);
    check_eq("first_valid_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("first_valid_k", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("first_valid_k1", 32'(out_valid), 32'd1);
    check_eq("first_word", out_dat, mem[12'h040]);
    finish_xfer(16, d);
    check_eq("b16_bursts", 32'(bursts), 32'd1);

    // Two bursts of 16 and 4
    start_xfer(32'h0000_0200, 20, 0);
    finish_xfer(20, d);
    check_eq("b20_bursts", 32'(bursts), 32'd2);

    // Stalled consumer: credit stops issue at FIFO capacity; start while busy is ignored
    rdy_mode = 0;
    start_xfer(32'h0000_0800, 128, 0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1; base_adr = 32'h0000_0000; nb_words = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("stall_acks", 32'(acked), 32'd64);
    check_eq("stall_cyc", 32'(wb.cyc), 32'd0);
    check_eq("stall_busy", 32'(busy), 32'd1);
    check_eq("stall_valid", 32'(out_valid), 32'd1);
    rdy_mode = 1;
    finish_xfer(128, d);
    check_eq("stall_bursts", 32'(bursts), 32'd8);

    // Slave wait states
    start_xfer(32'h0000_1004, 24, 3);
    finish_xfer(24, d);

    // Address wrap past 2^32
    start_xfer(32'hFFFF_FFF0, 8, 1);
    finish_xfer(8, d);

    // Reset mid-burst
    start_xfer(32'h0000_2000, 16, 0);
    for (int k = 0; k < 100 && acked < 5; k++) @(negedge clk);
    snap = done_cnt;
    #1 rst = 1'b1;
    #1;
    check_eq("arst_cyc", 32'(wb.cyc), 32'd0);
    check_eq("arst_stb", 32'(wb.stb), 32'd0);
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("arst_no_done", 32'(done_cnt), 32'(snap));
    start_xfer(32'h0000_3000, 4, 0);
    finish_xfer(4, d);

    // Random transfers
    for (int k = 0; k < 10; k++) begin
      rdy_mode = (k % 2 == 1) ? 2 : 1;
      b = $urandom_range(0, 32'h0000_3FFF);
      n = int'($urandom_range(0, 40));
      start_xfer(b, n, int'($urandom_range(0, 3)));
      finish_xfer(n, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
